// File: rtl/vm_pkg.sv
// Shared vending-machine definitions: coin values, ejector coin-select
// encodings and the payout FSM state type.
package vm_pkg;

  localparam int AMT_W_DEF = 7;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;
  localparam int COIN_20 = 20;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_5    = 2'd1,
    SEL_10   = 2'd2,
    SEL_20   = 2'd3
  } coin_sel_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PICK,
    ST_EJECT,
    ST_RELEASE,
    ST_DONE,
    ST_FAULT
  } payout_state_e;

  // Dollar value of a coin-select code.
  function automatic logic [4:0] coin_value(input coin_sel_e sel);
    case (sel)
      SEL_5:   coin_value = 5'(COIN_5);
      SEL_10:  coin_value = 5'(COIN_10);
      SEL_20:  coin_value = 5'(COIN_20);
      default: coin_value = '0;
    endcase
  endfunction

endpackage

// File: rtl/change_payout_unit_if.sv
// Coin ejector req/ack handshake. The payout unit is the master.
interface change_payout_unit_if;
  logic       eject_req;
  logic [1:0] eject_coin;
  logic       eject_ack;

  modport master (output eject_req, output eject_coin, input eject_ack);
  modport slave  (input eject_req, input eject_coin, output eject_ack);
endinterface

// File: rtl/coin_tube.sv
// Inventory counter for one coin tube; saturates at both ends.
module coin_tube #(
  parameter int W    = 6,
  parameter int INIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] cnt
);

  // Count refills up and ejections down, clamped to [0, 2^W-1].
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= W'(INIT);
    end else if (inc && !dec && cnt != '1) begin
      cnt <= cnt + 1'b1;
    end else if (dec && !inc && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/change_payout_unit.sv
// Change payout unit: turns a returned dollar amount into a greedy sequence
// of $20/$10/$5 coin ejections, tracking tube inventory, shortfall and
// ejector timeouts.
module change_payout_unit
  import vm_pkg::*;
#(
  parameter int AMT_W          = AMT_W_DEF,
  parameter int TUBE_W         = 6,
  parameter int INIT_TUBE      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [AMT_W-1:0]     change_out,
  input  logic                 change_ready,
  input  logic                 refill_valid,
  input  logic [4:0]           refill_coin,
  change_payout_unit_if.master eject,
  output logic                 busy,
  output logic                 payout_done,
  output logic [AMT_W-1:0]     paid_total,
  output logic [AMT_W-1:0]     shortfall,
  output logic                 fault,
  output logic [TUBE_W-1:0]    tube_cnt_5,
  output logic [TUBE_W-1:0]    tube_cnt_10,
  output logic [TUBE_W-1:0]    tube_cnt_20
);

  localparam int WC_W = $clog2(TIMEOUT_CYCLES + 1);

  payout_state_e    state;
  coin_sel_e        coin_sel;
  logic             req_q;
  logic             cr_q;
  logic             start_q;
  logic [AMT_W-1:0] start_amt;
  logic [AMT_W-1:0] remaining;
  logic [WC_W-1:0]  wait_cnt;

  logic refill_ok;
  logic ack_taken;
  logic inc_5, inc_10, inc_20;
  logic dec_5, dec_10, dec_20;

  assign eject.eject_req  = req_q;
  assign eject.eject_coin = coin_sel;

  // Refills land only while idle; ejections debit the selected tube on ack.
  always_comb begin
    refill_ok = refill_valid && (state == ST_IDLE);
    ack_taken = (state == ST_EJECT) && eject.eject_ack;
    inc_5     = refill_ok && (refill_coin == 5'(COIN_5));
    inc_10    = refill_ok && (refill_coin == 5'(COIN_10));
    inc_20    = refill_ok && (refill_coin == 5'(COIN_20));
    dec_5     = ack_taken && (coin_sel == SEL_5);
    dec_10    = ack_taken && (coin_sel == SEL_10);
    dec_20    = ack_taken && (coin_sel == SEL_20);
  end

  coin_tube #(.W(TUBE_W), .INIT(INIT_TUBE)) u_tube_5 (
    .clk(clk), .reset(reset), .inc(inc_5), .dec(dec_5), .cnt(tube_cnt_5)
  );

  coin_tube #(.W(TUBE_W), .INIT(INIT_TUBE)) u_tube_10 (
    .clk(clk), .reset(reset), .inc(inc_10), .dec(dec_10), .cnt(tube_cnt_10)
  );

  coin_tube #(.W(TUBE_W), .INIT(INIT_TUBE)) u_tube_20 (
    .clk(clk), .reset(reset), .inc(inc_20), .dec(dec_20), .cnt(tube_cnt_20)
  );

  // Payout FSM. All outputs are registered and set on the transition into
  // the state that owns them, so each state shows its own values. The
  // change_ready rise is registered into start_q first, giving one idle
  // cycle in which a coincident refill still lands before PICK looks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      coin_sel    <= SEL_NONE;
      req_q       <= 1'b0;
      cr_q        <= 1'b0;
      start_q     <= 1'b0;
      start_amt   <= '0;
      remaining   <= '0;
      wait_cnt    <= '0;
      busy        <= 1'b0;
      payout_done <= 1'b0;
      paid_total  <= '0;
      shortfall   <= '0;
      fault       <= 1'b0;
    end else begin
      cr_q        <= change_ready;
      start_q     <= change_ready && !cr_q && (state == ST_IDLE) && !fault;
      payout_done <= 1'b0;
      if (change_ready && !cr_q && (state == ST_IDLE)) begin
        start_amt <= change_out;
      end

      case (state)
        ST_IDLE: begin
          if (start_q) begin
            remaining  <= start_amt;
            paid_total <= '0;
            shortfall  <= '0;
            if (start_amt == '0) begin
              payout_done <= 1'b1;
              state       <= ST_DONE;
            end else begin
              busy  <= 1'b1;
              state <= ST_PICK;
            end
          end
        end

        ST_PICK: begin
          wait_cnt <= '0;
          if (remaining >= AMT_W'(COIN_20) && tube_cnt_20 != '0) begin
            coin_sel <= SEL_20;
            req_q    <= 1'b1;
            state    <= ST_EJECT;
          end else if (remaining >= AMT_W'(COIN_10) && tube_cnt_10 != '0) begin
            coin_sel <= SEL_10;
            req_q    <= 1'b1;
            state    <= ST_EJECT;
          end else if (remaining >= AMT_W'(COIN_5) && tube_cnt_5 != '0) begin
            coin_sel <= SEL_5;
            req_q    <= 1'b1;
            state    <= ST_EJECT;
          end else begin
            shortfall   <= remaining;
            busy        <= 1'b0;
            payout_done <= 1'b1;
            state       <= ST_DONE;
          end
        end

        ST_EJECT: begin
          if (eject.eject_ack) begin
            remaining  <= remaining - AMT_W'(coin_value(coin_sel));
            paid_total <= paid_total + AMT_W'(coin_value(coin_sel));
            req_q      <= 1'b0;
            coin_sel   <= SEL_NONE;
            state      <= ST_RELEASE;
          end else if (wait_cnt == WC_W'(TIMEOUT_CYCLES - 1)) begin
            fault       <= 1'b1;
            shortfall   <= remaining;
            req_q       <= 1'b0;
            coin_sel    <= SEL_NONE;
            busy        <= 1'b0;
            payout_done <= 1'b1;
            state       <= ST_FAULT;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end

        ST_RELEASE: begin
          if (!eject.eject_ack) begin
            state <= ST_PICK;
          end
        end

        ST_DONE:  state <= ST_IDLE;
        ST_FAULT: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_payout_unit.sv
// Directed testbench for change_payout_unit with a behavioural coin ejector
// that acknowledges each request three cycles after it rises.
module tb_change_payout_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [6:0] change_out = '0;
  logic       change_ready = 1'b0;
  logic       refill_valid = 1'b0;
  logic [4:0] refill_coin = '0;
  logic       busy, payout_done, fault;
  logic [6:0] paid_total, shortfall;
  logic [5:0] tube_cnt_5, tube_cnt_10, tube_cnt_20;

  change_payout_unit_if ej_if ();

  change_payout_unit #(
    .AMT_W(7), .TUBE_W(6), .INIT_TUBE(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .reset(reset), .change_out(change_out),
    .change_ready(change_ready), .refill_valid(refill_valid),
    .refill_coin(refill_coin), .eject(ej_if.master), .busy(busy),
    .payout_done(payout_done), .paid_total(paid_total),
    .shortfall(shortfall), .fault(fault), .tube_cnt_5(tube_cnt_5),
    .tube_cnt_10(tube_cnt_10), .tube_cnt_20(tube_cnt_20)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;
  int log_n    = 0;
  int log_word = 0;
  int req_age  = 0;
  bit ack_en   = 1'b1;

  // Ejector model and payout_done counter, sampled on the falling edge.
  initial begin
    ej_if.eject_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (ej_if.eject_req && ack_en) begin
        if (!ej_if.eject_ack) begin
          req_age++;
          if (req_age == 3) begin
            ej_if.eject_ack = 1'b1;
            log_word = log_word * 4 + int'(ej_if.eject_coin);
            log_n++;
          end
        end
      end else begin
        req_age = 0;
        ej_if.eject_ack = 1'b0;
      end
      if (payout_done) done_cnt++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    else n_pass++;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    change_ready = 1'b0;
    refill_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  // Returns at the falling edge after edge N+1 (N = edge sampling the rise).
  task automatic start_payout(input logic [6:0] amt, input bit refill20);
    @(negedge clk);
    change_ready = 1'b0;
    done_cnt = 0; log_n = 0; log_word = 0;
    @(negedge clk);
    change_out = amt;
    change_ready = 1'b1;
    @(negedge clk);
    if (refill20) begin
      refill_valid = 1'b1;
      refill_coin = 5'd20;
    end
    @(negedge clk);
    refill_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (payout_done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({name, "_done_seen"}, int'(seen), 1);
  endtask

  task automatic test_reset();
    apply_reset();
    chk("rst_req", int'(ej_if.eject_req), 0);
    chk("rst_coin", int'(ej_if.eject_coin), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(payout_done), 0);
    chk("rst_paid", int'(paid_total), 0);
    chk("rst_short", int'(shortfall), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_t20", int'(tube_cnt_20), 4);
    chk("rst_t10", int'(tube_cnt_10), 4);
    chk("rst_t5", int'(tube_cnt_5), 4);
  endtask

  task automatic test_zero_amount();
    start_payout(7'd0, 1'b0);
    chk("zero_done", int'(payout_done), 1);
    chk("zero_busy", int'(busy), 0);
    repeat (4) @(negedge clk);
    chk("zero_paid", int'(paid_total), 0);
    chk("zero_short", int'(shortfall), 0);
    chk("zero_ejects", log_n, 0);
  endtask

  task automatic test_pay_15();
    start_payout(7'd15, 1'b0);
    chk("p15_req_n1", int'(ej_if.eject_req), 0);
    chk("p15_busy", int'(busy), 1);
    @(negedge clk);
    chk("p15_req_n2", int'(ej_if.eject_req), 1);
    chk("p15_coin", int'(ej_if.eject_coin), 2);
    wait_done("p15");
    chk("p15_paid", int'(paid_total), 15);
    chk("p15_short", int'(shortfall), 0);
    chk("p15_log", log_word, 9);
    chk("p15_t20", int'(tube_cnt_20), 4);
    chk("p15_t10", int'(tube_cnt_10), 3);
    chk("p15_t5", int'(tube_cnt_5), 3);
    repeat (6) @(negedge clk);
    chk("p15_single_done", done_cnt, 1);
    chk("p15_no_retrigger", int'(busy), 0);
  endtask

  task automatic test_pay_30();
    start_payout(7'd30, 1'b0);
    wait_done("p30");
    chk("p30_paid", int'(paid_total), 30);
    chk("p30_short", int'(shortfall), 0);
    chk("p30_log", log_word, 14);
    chk("p30_t20", int'(tube_cnt_20), 3);
    chk("p30_t10", int'(tube_cnt_10), 2);
  endtask

  task automatic test_pay_7_busy_rise();
    start_payout(7'd7, 1'b0);
    @(negedge clk);
    change_ready = 1'b0;
    @(negedge clk);
    change_ready = 1'b1;
    wait_done("p7");
    chk("p7_paid", int'(paid_total), 5);
    chk("p7_short", int'(shortfall), 2);
    chk("p7_log", log_word, 1);
    chk("p7_t5", int'(tube_cnt_5), 2);
    repeat (8) @(negedge clk);
    chk("p7_busy_rise_ignored", done_cnt, 1);
  endtask

  task automatic test_refill();
    @(negedge clk);
    refill_valid = 1'b1; refill_coin = 5'd20;
    @(negedge clk);
    refill_valid = 1'b0;
    chk("ref_t20", int'(tube_cnt_20), 4);
    refill_valid = 1'b1; refill_coin = 5'd15;
    @(negedge clk);
    refill_valid = 1'b0;
    chk("ref_bad_t5", int'(tube_cnt_5), 2);
    chk("ref_bad_t10", int'(tube_cnt_10), 2);
    chk("ref_bad_t20", int'(tube_cnt_20), 4);
    refill_valid = 1'b1; refill_coin = 5'd10;
    repeat (2) @(negedge clk);
    refill_valid = 1'b0;
    chk("ref_t10", int'(tube_cnt_10), 4);
  endtask

  task automatic test_drain_20();
    start_payout(7'd80, 1'b0);
    wait_done("p80");
    chk("p80_paid", int'(paid_total), 80);
    chk("p80_log", log_word, 255);
    chk("p80_t20", int'(tube_cnt_20), 0);
    start_payout(7'd40, 1'b0);
    wait_done("p40");
    chk("p40_paid", int'(paid_total), 40);
    chk("p40_short", int'(shortfall), 0);
    chk("p40_log", log_word, 170);
    chk("p40_t10", int'(tube_cnt_10), 0);
  endtask

  task automatic test_refill_at_start();
    start_payout(7'd20, 1'b1);
    wait_done("pst");
    chk("pst_paid", int'(paid_total), 20);
    chk("pst_log", log_word, 3);
    chk("pst_t20", int'(tube_cnt_20), 0);
  endtask

  task automatic test_fault();
    int  req_cycles = 0;
    bit  seen = 1'b0;
    bit  activity = 1'b0;
    ack_en = 1'b0;
    start_payout(7'd5, 1'b0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (ej_if.eject_req) req_cycles++;
      refill_valid = (req_cycles == 3) && ej_if.eject_req;
      refill_coin  = 5'd5;
      if (payout_done) begin
        seen = 1'b1;
        break;
      end
    end
    refill_valid = 1'b0;
    chk("flt_done_seen", int'(seen), 1);
    chk("flt_req_cycles", req_cycles, 16);
    chk("flt_fault", int'(fault), 1);
    chk("flt_req_low", int'(ej_if.eject_req), 0);
    chk("flt_busy", int'(busy), 0);
    chk("flt_short", int'(shortfall), 5);
    chk("flt_paid", int'(paid_total), 0);
    chk("flt_t5_busy_refill", int'(tube_cnt_5), 2);
    change_ready = 1'b0;
    @(negedge clk);
    change_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy || ej_if.eject_req || payout_done) activity = 1'b1;
    end
    chk("flt_edge_ignored", int'(activity), 0);
    chk("flt_sticky", int'(fault), 1);
    ack_en = 1'b1;
  endtask

  task automatic test_reset_mid_op();
    apply_reset();
    chk("mr_fault_clr", int'(fault), 0);
    ack_en = 1'b0;
    start_payout(7'd10, 1'b0);
    @(negedge clk);
    chk("mr_req_up", int'(ej_if.eject_req), 1);
    #2 reset = 1'b0;
    #1;
    chk("mr_req_drop", int'(ej_if.eject_req), 0);
    chk("mr_t20", int'(tube_cnt_20), 4);
    chk("mr_t10", int'(tube_cnt_10), 4);
    chk("mr_t5", int'(tube_cnt_5), 4);
    chk("mr_busy", int'(busy), 0);
    @(negedge clk);
    change_ready = 1'b0;
    reset = 1'b1;
    ack_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("mr_idle_after", int'(ej_if.eject_req), 0);
  endtask

  initial begin
    test_reset();
    test_zero_amount();
    test_pay_15();
    test_pay_30();
    test_pay_7_busy_rise();
    test_refill();
    test_drain_20();
    test_refill_at_start();
    test_fault();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
